// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe controller: mark codes, FSM
// state encoding, the eight winning line masks and a board cell accessor.
package ttt_pkg;

  typedef enum logic [1:0] {
    MARK_EMPTY = 2'd0,
    MARK_X     = 2'd1,
    MARK_O     = 2'd2,
    MARK_DRAW  = 2'd3
  } mark_t;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  localparam int unsigned N_CELLS = 9;
  localparam int unsigned N_LINES = 8;

  // Cell masks of the eight lines. Index 0..2 rows, 3..5 columns,
  // 6 main diagonal (0,4,8), 7 anti-diagonal (2,4,6).
  localparam logic [N_LINES-1:0][N_CELLS-1:0] WIN_LINES = {
    9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
  };

  // Mark held by cell k; out-of-range cells read as empty.
  function automatic logic [1:0] cell_of(input logic [17:0] board, input logic [3:0] k);
    logic [1:0] v;
    v = MARK_EMPTY;
    if (k < 4'd9) v = board[2*int'(k) +: 2];
    return v;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational line detector: reports which of the eight lines are fully
// owned by a given mark and the union of their cells.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  input  logic [1:0]  mark,
  output logic [7:0]  line_hit,
  output logic [8:0]  win_mask
);

  logic [8:0] w_owned;

  // Flag every cell that holds the queried mark.
  always_comb begin
    w_owned = '0;
    for (int k = 0; k < 9; k++) begin
      w_owned[k] = (cell_of(board, 4'(k)) == mark);
    end
  end

  // A line is hit when all its cells are owned; the mask ORs every hit line.
  always_comb begin
    line_hit = '0;
    win_mask = '0;
    for (int l = 0; l < 8; l++) begin
      line_hit[l] = ((WIN_LINES[l] & w_owned) == WIN_LINES[l]);
      if (line_hit[l]) win_mask = win_mask | WIN_LINES[l];
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer and sole writer of the display board.
// Accepts key moves, alternates players, detects win/draw, optionally
// forfeits idle turns, and freezes until a new game is requested.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic [1:0]  START_MARK   = 2'd1,
  parameter int unsigned TURN_TIMEOUT = 0
)(
  input  logic        freq,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_cell,
  input  logic        key_new_game,
  output logic [17:0] board,
  output logic [1:0]  turn_mark,
  output logic        move_ack,
  output logic        move_err,
  output logic        turn_skip,
  output logic [3:0]  move_count,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [8:0]  win_mask
);

  // Anything other than O starts with X.
  localparam logic [1:0] FIRST_MARK = (START_MARK == 2'd2) ? 2'd2 : 2'd1;
  localparam logic       TMO_EN     = (TURN_TIMEOUT > 0);
  localparam int         CNT_W      = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TURN_TIMEOUT - 1) : '0;

  state_t           r_state,     w_state_nxt;
  logic [17:0]      r_board,     w_board_nxt;
  logic [1:0]       r_turn,      w_turn_nxt;
  logic [3:0]       r_count,     w_count_nxt;
  logic             r_over,      w_over_nxt;
  logic [1:0]       r_winner,    w_winner_nxt;
  logic [8:0]       r_win_mask,  w_win_mask_nxt;
  logic             r_ack,       w_ack_nxt;
  logic             r_err,       w_err_nxt;
  logic             r_skip,      w_skip_nxt;
  logic [CNT_W-1:0] r_tmo_cnt,   w_tmo_cnt_nxt;

  logic [7:0] w_line_hit;
  logic [8:0] w_line_mask;
  logic       w_legal;
  logic       w_expire;
  logic [1:0] w_turn_other;

  ttt_line_check u_line_check (
    .board    (r_board),
    .mark     (r_turn),
    .line_hit (w_line_hit),
    .win_mask (w_line_mask)
  );

  assign w_legal      = key_valid && (key_cell <= 4'd8) && (cell_of(r_board, key_cell) == MARK_EMPTY);
  assign w_expire     = TMO_EN && (r_tmo_cnt == CNT_LAST);
  assign w_turn_other = (r_turn == MARK_X) ? MARK_O : MARK_X;

  // Next-state and next-output logic for the PLAY/CHECK/OVER sequencer.
  always_comb begin
    // NOTE: every next value is defaulted first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_board_nxt    = r_board;
    w_turn_nxt     = r_turn;
    w_count_nxt    = r_count;
    w_over_nxt     = r_over;
    w_winner_nxt   = r_winner;
    w_win_mask_nxt = r_win_mask;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_skip_nxt     = 1'b0;

    if (key_new_game) begin
      // New game outranks any move on the same cycle; that move is dropped silently.
      w_state_nxt    = ST_PLAY;
      w_board_nxt    = '0;
      w_turn_nxt     = FIRST_MARK;
      w_count_nxt    = '0;
      w_over_nxt     = 1'b0;
      w_winner_nxt   = MARK_EMPTY;
      w_win_mask_nxt = '0;
      w_tmo_cnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (w_legal) begin
            // A legal move beats a timeout expiring on the same cycle.
            w_board_nxt[2*int'(key_cell) +: 2] = r_turn;
            w_count_nxt = (r_count == 4'd9) ? r_count : r_count + 4'd1;
            w_ack_nxt   = 1'b1;
            w_state_nxt = ST_CHECK;
          end else if (w_expire) begin
            // Forfeit; an illegal key here is swallowed so only one pulse fires.
            w_turn_nxt    = w_turn_other;
            w_skip_nxt    = 1'b1;
            w_tmo_cnt_nxt = '0;
          end else begin
            w_err_nxt = key_valid;
            if (TMO_EN) w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          w_err_nxt = key_valid;
          if (|w_line_hit) begin
            w_state_nxt    = ST_OVER;
            w_over_nxt     = 1'b1;
            w_winner_nxt   = r_turn;
            w_win_mask_nxt = w_line_mask;
          end else if (r_count == 4'd9) begin
            w_state_nxt    = ST_OVER;
            w_over_nxt     = 1'b1;
            w_winner_nxt   = MARK_DRAW;
            w_win_mask_nxt = '0;
          end else begin
            w_state_nxt   = ST_PLAY;
            w_turn_nxt    = w_turn_other;
            w_tmo_cnt_nxt = '0;
          end
        end
        ST_OVER: begin
          w_err_nxt = key_valid;
        end
        default: begin
          w_state_nxt = ST_PLAY;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge freq) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      r_state    <= ST_PLAY;
      r_board    <= '0;
      r_turn     <= FIRST_MARK;
      r_count    <= '0;
      r_over     <= 1'b0;
      r_winner   <= MARK_EMPTY;
      r_win_mask <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_skip     <= 1'b0;
      r_tmo_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_board    <= w_board_nxt;
      r_turn     <= w_turn_nxt;
      r_count    <= w_count_nxt;
      r_over     <= w_over_nxt;
      r_winner   <= w_winner_nxt;
      r_win_mask <= w_win_mask_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_skip     <= w_skip_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
    end
  end

  assign board      = r_board;
  assign turn_mark  = r_turn;
  assign move_ack   = r_ack;
  assign move_err   = r_err;
  assign turn_skip  = r_skip;
  assign move_count = r_count;
  assign game_over  = r_over;
  assign winner     = r_winner;
  assign win_mask   = r_win_mask;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl. A reference model predicts every cycle's
// outputs of the default instance into a scoreboard queue; a second instance
// with TURN_TIMEOUT=16 is checked directly for the forfeit behaviour.
module tb_ttt_game_ctrl;

  logic        freq = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_cell = 4'd0;
  logic        key_new_game = 1'b0;

  logic [17:0] board,   t_board;
  logic [1:0]  turn_mark, t_turn;
  logic        move_ack, t_ack;
  logic        move_err, t_err;
  logic        turn_skip, t_skip;
  logic [3:0]  move_count, t_count;
  logic        game_over, t_over;
  logic [1:0]  winner, t_winner;
  logic [8:0]  win_mask, t_mask;

  always #5 freq = ~freq;

  ttt_game_ctrl dut (
    .freq(freq), .rst(rst), .key_valid(key_valid), .key_cell(key_cell),
    .key_new_game(key_new_game), .board(board), .turn_mark(turn_mark),
    .move_ack(move_ack), .move_err(move_err), .turn_skip(turn_skip),
    .move_count(move_count), .game_over(game_over), .winner(winner), .win_mask(win_mask)
  );

  ttt_game_ctrl #(.TURN_TIMEOUT(16)) dut_t (
    .freq(freq), .rst(rst), .key_valid(key_valid), .key_cell(key_cell),
    .key_new_game(key_new_game), .board(t_board), .turn_mark(t_turn),
    .move_ack(t_ack), .move_err(t_err), .turn_skip(t_skip),
    .move_count(t_count), .game_over(t_over), .winner(t_winner), .win_mask(t_mask)
  );

  typedef struct {
    string       tag;
    logic [17:0] board;
    logic [1:0]  turn;
    logic        ack, err, skip;
    logic [3:0]  cnt;
    logic        over;
    logic [1:0]  winner;
    logic [8:0]  mask;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [1:0] m_cell [9];
  logic [1:0] m_turn, m_winner;
  logic [3:0] m_cnt;
  logic       m_over, m_ack, m_err, m_skip;
  logic [8:0] m_mask;
  int         m_state;  // 0 play, 1 check, 2 over
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 9; k++) m_cell[k] = 2'd0;
    m_turn = 2'd1; m_cnt = 4'd0; m_over = 1'b0; m_winner = 2'd0;
    m_mask = 9'd0; m_state = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c, input logic ng, input logic rn);
    logic       won;
    logic [8:0] mk;
    m_ack = 1'b0; m_err = 1'b0; m_skip = 1'b0;
    if (!rn || ng) begin
      model_clear();
    end else if (m_state == 0) begin
      if (v) begin
        m_err = 1'b1;
        if (c < 4'd9) begin
          if (m_cell[int'(c)] == 2'd0) begin
            m_cell[int'(c)] = m_turn;
            m_cnt = m_cnt + 4'd1;
            m_ack = 1'b1;
            m_err = 1'b0;
            m_state = 1;
          end
        end
      end
    end else if (m_state == 1) begin
      m_err = v;
      won = 1'b0; mk = 9'd0;
      for (int l = 0; l < 8; l++) begin
        if (m_cell[lines[l][0]] == m_turn && m_cell[lines[l][1]] == m_turn &&
            m_cell[lines[l][2]] == m_turn) begin
          won = 1'b1;
          for (int j = 0; j < 3; j++) mk[lines[l][j]] = 1'b1;
        end
      end
      if (won) begin
        m_state = 2; m_over = 1'b1; m_winner = m_turn; m_mask = mk;
      end else if (m_cnt == 4'd9) begin
        m_state = 2; m_over = 1'b1; m_winner = 2'd3; m_mask = 9'd0;
      end else begin
        m_turn = 2'd3 - m_turn; m_state = 0;
      end
    end else begin
      m_err = v;
    end
  endtask

  // Drive one cycle, predict into the scoreboard, then compare after the edge.
  task automatic step(input string tag, input logic v, input logic [3:0] c,
                      input logic ng, input logic rn);
    exp_t e;
    key_valid = v; key_cell = c; key_new_game = ng; rst = rn;
    model_step(v, c, ng, rn);
    e.tag = tag;
    for (int k = 0; k < 9; k++) e.board[2*k +: 2] = m_cell[k];
    e.turn = m_turn; e.ack = m_ack; e.err = m_err; e.skip = m_skip;
    e.cnt = m_cnt; e.over = m_over; e.winner = m_winner; e.mask = m_mask;
    sb.push_back(e);
    @(posedge freq);
    #1;
    key_valid = 1'b0; key_new_game = 1'b0; rst = 1'b1;
    e = sb.pop_front();
    chk({e.tag, ".board"},  32'(board),      32'(e.board));
    chk({e.tag, ".turn"},   32'(turn_mark),  32'(e.turn));
    chk({e.tag, ".ack"},    32'(move_ack),   32'(e.ack));
    chk({e.tag, ".err"},    32'(move_err),   32'(e.err));
    chk({e.tag, ".skip"},   32'(turn_skip),  32'(e.skip));
    chk({e.tag, ".count"},  32'(move_count), 32'(e.cnt));
    chk({e.tag, ".over"},   32'(game_over),  32'(e.over));
    chk({e.tag, ".winner"}, 32'(winner),     32'(e.winner));
    chk({e.tag, ".mask"},   32'(win_mask),   32'(e.mask));
  endtask

  task automatic play(input string tag, input logic [3:0] c);
    step({tag, " move"}, 1'b1, c, 1'b0, 1'b1);
    step({tag, " check"}, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, then X wins on the main diagonal
    step("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    chk("reset.board_const", 32'(board), 32'h0);
    chk("reset.turn_const", 32'(turn_mark), 32'd1);
    play("t1 X0", 4'd0);
    play("t1 O1", 4'd1);
    play("t1 X4", 4'd4);
    play("t1 O2", 4'd2);
    step("t1 X8", 1'b1, 4'd8, 1'b0, 1'b1);
    chk("t1.board_n1", 32'(board), 32'h10129);
    chk("t1.over_n1", 32'(game_over), 32'd0);
    step("t1 check", 1'b0, 4'd0, 1'b0, 1'b1);
    chk("t1.over_n2", 32'(game_over), 32'd1);
    chk("t1.winner_n2", 32'(winner), 32'd1);
    chk("t1.mask_n2", 32'(win_mask), 32'h111);
    step("t1 key in over", 1'b1, 4'd5, 1'b0, 1'b1);

    // 2: occupied cell rejected
    step("t2 newgame", 1'b0, 4'd0, 1'b1, 1'b1);
    step("t2 X4", 1'b1, 4'd4, 1'b0, 1'b1);
    chk("t2.ack", 32'(move_ack), 32'd1);
    step("t2 check", 1'b0, 4'd0, 1'b0, 1'b1);
    chk("t2.turn", 32'(turn_mark), 32'd2);
    step("t2 X4 again", 1'b1, 4'd4, 1'b0, 1'b1);
    chk("t2.err", 32'(move_err), 32'd1);
    chk("t2.board", 32'(board), 32'h00100);
    chk("t2.turn_held", 32'(turn_mark), 32'd2);

    // 3: full-board draw
    step("t3 newgame", 1'b0, 4'd0, 1'b1, 1'b1);
    play("t3 X0", 4'd0); play("t3 O1", 4'd1); play("t3 X2", 4'd2);
    play("t3 O4", 4'd4); play("t3 X3", 4'd3); play("t3 O5", 4'd5);
    play("t3 X7", 4'd7); play("t3 O6", 4'd6); play("t3 X8", 4'd8);
    chk("t3.count", 32'(move_count), 32'd9);
    chk("t3.winner", 32'(winner), 32'd3);
    chk("t3.mask", 32'(win_mask), 32'd0);
    step("t3 key after draw", 1'b1, 4'd0, 1'b0, 1'b1);
    chk("t3.err", 32'(move_err), 32'd1);

    // 4: out-of-range cells
    step("t4 newgame", 1'b0, 4'd0, 1'b1, 1'b1);
    step("t4 cell12", 1'b1, 4'd12, 1'b0, 1'b1);
    chk("t4.err", 32'(move_err), 32'd1);
    chk("t4.board", 32'(board), 32'd0);
    chk("t4.count", 32'(move_count), 32'd0);
    step("t4 cell9", 1'b1, 4'd9, 1'b0, 1'b1);
    step("t4 cell8", 1'b1, 4'd8, 1'b0, 1'b1);
    step("t4 check", 1'b0, 4'd0, 1'b0, 1'b1);

    // 5: timeout instance, forfeit after 16 idle cycles, then a move on cycle 15
    step("t5 reset", 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step("t5 idle", 1'b0, 4'd0, 1'b0, 1'b1);
      chk("t5.no_skip", 32'(t_skip), 32'd0);
      chk("t5.turn_x", 32'(t_turn), 32'd1);
    end
    step("t5 expire", 1'b0, 4'd0, 1'b0, 1'b1);
    chk("t5.skip", 32'(t_skip), 32'd1);
    chk("t5.turn_o", 32'(t_turn), 32'd2);
    for (int i = 0; i < 15; i++) begin
      step("t5 idle2", 1'b0, 4'd0, 1'b0, 1'b1);
      chk("t5.no_skip2", 32'(t_skip), 32'd0);
    end
    step("t5 late move", 1'b1, 4'd3, 1'b0, 1'b1);
    chk("t5.late_ack", 32'(t_ack), 32'd1);
    chk("t5.late_no_skip", 32'(t_skip), 32'd0);
    chk("t5.late_board", 32'(t_board), 32'h00080);
    step("t5 check", 1'b0, 4'd0, 1'b0, 1'b1);
    chk("t5.turn_back", 32'(t_turn), 32'd1);

    // 6: new game beats a simultaneous move; reset during CHECK
    step("t6 newgame", 1'b0, 4'd0, 1'b1, 1'b1);
    play("t6 X0", 4'd0);
    play("t6 O4", 4'd4);
    step("t6 ng+key", 1'b1, 4'd8, 1'b1, 1'b1);
    chk("t6.ng_ack", 32'(move_ack), 32'd0);
    chk("t6.ng_err", 32'(move_err), 32'd0);
    chk("t6.ng_board", 32'(board), 32'd0);
    chk("t6.ng_turn", 32'(turn_mark), 32'd1);
    step("t6 X2", 1'b1, 4'd2, 1'b0, 1'b1);
    step("t6 rst in check", 1'b0, 4'd0, 1'b0, 1'b0);
    chk("t6.rst_board", 32'(board), 32'd0);
    chk("t6.rst_count", 32'(move_count), 32'd0);
    chk("t6.rst_turn", 32'(turn_mark), 32'd1);
    play("t6 X5 after rst", 4'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
